// File: rtl/pdm_decimator.sv
// Third-order CIC (sinc^3) decimator: 1-bit PDM stream in, unsigned PCM samples out.
// Integrators run every clock; the comb section and output register update once per DECIM cycles.
module pdm_decimator #(
  parameter int DECIM = 512,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pdm,
  output logic [OUT_W-1:0] sample,
  output logic             sample_valid
);

  localparam int L  = $clog2(DECIM);
  localparam int W  = 3 * L + 1;
  localparam int SH = 3 * L - OUT_W;
  localparam logic [W-1:0] FULL = {1'b1, {(3 * L){1'b0}}};

  logic [W-1:0] i1, i2, i3;
  logic [W-1:0] d1, d2, d3;
  logic [W-1:0] c0, c1, c2, c3;
  logic [L-1:0] ph;
  logic [1:0]   wu;
  logic         tick;

  // DECIM is a power of two, so the last phase is all ones.
  assign tick = &ph;

  // All arithmetic wraps modulo 2^W; the comb differences cancel the integrator overflow.
  assign c0 = i3;
  assign c1 = c0 - d1;
  assign c2 = c1 - d2;
  assign c3 = c2 - d3;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      i1 <= '0;
      i2 <= '0;
      i3 <= '0;
      ph <= '0;
    end else begin
      i1 <= i1 + {{(W-1){1'b0}}, pdm};
      i2 <= i2 + i1;
      i3 <= i3 + i2;
      ph <= ph + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
    end else if (tick) begin
      d1 <= c0;
      d2 <= c1;
      d3 <= c2;
    end
  end

  // Warm-up: the first three ticks see a partially filled pipeline and are not strobed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wu <= '0;
    end else if (tick && (wu != 2'd3)) begin
      wu <= wu + 2'd1;
    end
  end

  // Only a constant-ones frame reaches FULL; clamp it instead of letting it truncate to zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= tick && (wu == 2'd3);
      if (tick) begin
        if (c3 >= FULL) sample <= '1;
        else            sample <= c3[SH +: OUT_W];
      end
    end
  end

endmodule

// File: tb/tb_pdm_decimator.sv
// Bench for pdm_decimator: expected samples come from a direct sinc^3 convolution of the
// recorded bitstream (box*box*box kernel), independent of any integrator/comb structure.
module tb_pdm_decimator;

  localparam int D  = 512;
  localparam int KL = 3 * D - 2;
  localparam longint FS = longint'(D) * D * D;
  localparam int SHIFT = 3 * 9 - 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        pdm = 1'b0;
  logic [15:0] sample;
  logic        sample_valid;

  int n_cmp = 0;
  int n_err = 0;

  bit     x_q[$];
  longint h[KL];

  pdm_decimator #(.DECIM(D), .OUT_W(16)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .pdm          (pdm),
    .sample       (sample),
    .sample_valid (sample_valid)
  );

  // clock / bitstream recorder
  always #5 clk = ~clk;

  always @(posedge clk) if (rstn) x_q.push_back(pdm);

  // sinc^3 kernel = three length-D boxes convolved
  task automatic build_kernel();
    longint h2[2*D-1];
    for (int j = 0; j < 2*D-1; j++) h2[j] = (j + 1 < 2*D-1-j) ? j + 1 : 2*D-1-j;
    for (int j = 0; j < KL; j++) begin
      h[j] = 0;
      for (int i = 0; i < D; i++)
        if (j - i >= 0 && j - i <= 2*D-2) h[j] += h2[j-i];
    end
  endtask

  // Output registered at edge t uses bits up to edge t-3 (integrator pipeline depth).
  function automatic logic [15:0] model_sample(int t);
    longint acc = 0;
    for (int j = 0; j < KL; j++)
      if (t - 3 - j >= 0) acc += h[j] * longint'(x_q[t-3-j]);
    if (acc >= FS) return 16'hFFFF;
    return 16'(acc >> SHIFT);
  endfunction

  function automatic bit model_valid(int e);
    return (e >= 4*D-1) && ((e + 1) % D == 0);
  endfunction

  // driver tasks
  task automatic do_reset();
    pdm = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    x_q.delete();
    rstn = 1'b1;
  endtask

  task automatic step(input bit b, output int e);
    pdm = b;
    @(posedge clk);
    @(negedge clk);
    e = x_q.size() - 1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pdm = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_cmp++;
      if (sample !== 16'h0 || sample_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_state: sample=%h valid=%b, required 0000/0", sample, sample_valid);
      end
    end
  endtask

  task automatic test_const(input bit b, input int frames, input logic [15:0] want);
    int e;
    do_reset();
    for (int k = 0; k < frames * D; k++) begin
      step(b, e);
      n_cmp++;
      if (sample_valid !== model_valid(e)) begin
        n_err++;
        $display("FAIL const%0d_valid edge %0d: got %b, required %b", b, e, sample_valid, model_valid(e));
      end
      if (model_valid(e)) begin
        n_cmp++;
        if (sample !== want || sample !== model_sample(e)) begin
          n_err++;
          $display("FAIL const%0d_sample edge %0d: got %h, required %h", b, e, sample, want);
        end
      end
    end
  endtask

  task automatic test_periodic(input int period, input logic [15:0] want);
    int e;
    do_reset();
    for (int k = 0; k < 8 * D; k++) begin
      step(bit'((k % period) == 0), e);
      n_cmp++;
      if (sample_valid !== model_valid(e)) begin
        n_err++;
        $display("FAIL period%0d_valid edge %0d: got %b, required %b", period, e, sample_valid, model_valid(e));
      end
      if (model_valid(e)) begin
        n_cmp++;
        if (sample !== want || sample !== model_sample(e)) begin
          n_err++;
          $display("FAIL period%0d_sample edge %0d: got %h, required %h", period, e, sample, want);
        end
      end
    end
  endtask

  task automatic test_random();
    int e;
    int dens = 128;
    logic [15:0] exp_q[$];
    do_reset();
    for (int k = 0; k < 20 * D; k++) begin
      if (k % D == 0) dens = $urandom_range(0, 256);
      step(bit'($urandom_range(0, 255) < dens), e);
      if (model_valid(e)) exp_q.push_back(model_sample(e));
      n_cmp++;
      if (sample_valid !== model_valid(e)) begin
        n_err++;
        $display("FAIL random_valid edge %0d: got %b, required %b", e, sample_valid, model_valid(e));
      end
      if (sample_valid === 1'b1 && exp_q.size() > 0) begin
        logic [15:0] want = exp_q.pop_front();
        n_cmp++;
        if (sample !== want) begin
          n_err++;
          $display("FAIL random_sample edge %0d: got %h, required %h", e, sample, want);
        end
      end
    end
  endtask

  task automatic test_loopback();
    int e;
    int acc = 0;
    bit b;
    do_reset();
    for (int k = 0; k < 12 * D; k++) begin
      acc = acc + 32'h3000;
      b = (acc >= 65536);
      acc = acc & 32'hFFFF;
      step(b, e);
      n_cmp++;
      if (sample_valid !== model_valid(e)) begin
        n_err++;
        $display("FAIL loopback_valid edge %0d: got %b, required %b", e, sample_valid, model_valid(e));
      end
      if (model_valid(e)) begin
        n_cmp++;
        if (sample !== model_sample(e) || int'(sample) < 16'h2FFE || int'(sample) > 16'h3002) begin
          n_err++;
          $display("FAIL loopback_sample edge %0d: got %h, required %h (3000 +/- 2)", e, sample, model_sample(e));
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int e;
    int first = -1;
    do_reset();
    for (int k = 0; k < 3000; k++) step(1'b1, e);
    n_cmp++;
    if (sample !== 16'hFFFF) begin
      n_err++;
      $display("FAIL midreset_pre: sample=%h, required ffff", sample);
    end
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if (sample !== 16'h0 || sample_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_async: sample=%h valid=%b, required 0000/0", sample, sample_valid);
    end
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (sample !== 16'h0 || sample_valid !== 1'b0) begin
        n_err++;
        $display("FAIL midreset_hold: sample=%h valid=%b, required 0000/0", sample, sample_valid);
      end
    end
    x_q.delete();
    rstn = 1'b1;
    for (int k = 0; k < 5 * D; k++) begin
      step(1'b1, e);
      if (sample_valid === 1'b1 && first < 0) first = e;
      n_cmp++;
      if (sample_valid !== model_valid(e)) begin
        n_err++;
        $display("FAIL midreset_valid edge %0d: got %b, required %b", e, sample_valid, model_valid(e));
      end
      if (model_valid(e)) begin
        n_cmp++;
        if (sample !== 16'hFFFF) begin
          n_err++;
          $display("FAIL midreset_sample edge %0d: got %h, required ffff", e, sample);
        end
      end
    end
    n_cmp++;
    if (first != 4*D-1) begin
      n_err++;
      $display("FAIL midreset_first_strobe: edge %0d, required %0d", first, 4*D-1);
    end
  endtask

  initial begin
    build_kernel();
    test_reset();
    test_const(1'b0, 6, 16'h0000);
    test_const(1'b1, 40, 16'hFFFF);
    test_periodic(2, 16'h8000);
    test_periodic(4, 16'h4000);
    test_random();
    test_loopback();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pdm_decimator.md
# pdm_decimator

Receive-side counterpart of the synth's 1-bit sigma-delta DAC output: it converts the `data` bitstream back into 16-bit unsigned PCM samples. It uses a 3rd-order CIC (sinc³) decimator clocked at the modulator rate (20.48 MHz) with decimation 512, producing one sample per 40 kHz frame. It serves as the loopback/verification path for the audio chain and as the front end for a future PDM microphone input.

## Interface
Parameters:
- `DECIM`, default 512: decimation ratio. Power of two, 4..4096; `3*log2(DECIM) >= OUT_W`.
- `OUT_W`, default 16: output sample width.

Ports:
- `clk`  in  1  modulator-rate clock (20.48 MHz); one PDM bit per cycle.
- `rstn`  in  1  reset; one clock; reset is asynchronous and active-low.
- `pdm`  in  1  PDM bitstream, 1 = +full scale, 0 = zero; already synchronous to `clk`.
- `sample`  out  OUT_W  decimated unsigned PCM sample; holds its value between strobes.
- `sample_valid`  out  1  one-cycle strobe; `sample` is new in that cycle.

## Operation
- Internal width `W = 3*log2(DECIM) + 1` (28 for defaults). All integrator and comb arithmetic is modulo 2^W. Wrap-around is required and must not be saturated: CIC correctness depends on it.
- Integrators run every `clk`, pipelined:
  - `i1 <= i1 + pdm` (zero-extended)
  - `i2 <= i2 + i1`
  - `i3 <= i3 + i2`
- Phase counter `ph`, log2(DECIM) bits, increments every cycle and wraps DECIM-1 -> 0. A tick is a cycle with `ph == DECIM-1`.
- Comb section updates only on tick cycles:
  - `c0 = i3`, `c1 = c0 - d1`, `c2 = c1 - d2`, `c3 = c2 - d3`
  - `d1 <= c0`, `d2 <= c1`, `d3 <= c2`
- Output scaling, registered on a tick:
  - Full-scale value is `F = DECIM^3` (2^27).
  - `sample <= (c3 >= F) ? all-ones : c3 >> (3*log2(DECIM) - OUT_W)`.
  - Only `c3 == F` (constant 1s) can reach saturation, so all-ones input yields 0xFFFF, not 0.
- Warm-up: a 2-bit counter `wu` counts ticks after reset and saturates at 3.
  - `sample_valid` is suppressed while `wu < 3` at the tick.
  - The first strobe comes from the 4th tick.
  - `sample` still updates during warm-up; its value is don't-care until the first strobe.
- There is no back-pressure. The consumer must take `sample` within DECIM cycles of the strobe.

## Timing
- Reset (async assert, sync release) clears to 0: `i1..i3`, `d1..d3`, `ph`, `wu`, `sample`, `sample_valid`.
- Cycle numbering: cycle 0 is the first rising edge with `rstn` high. Ticks occur at cycles 511, 1023, 1535, 2047, ... (k*DECIM - 1).
- `sample` and `sample_valid` are registered, visible in the cycle after a tick. First `sample_valid` is high in cycle 2048, then every 512 cycles. The strobe is exactly one cycle wide.
- Latency: `pdm` sampled at cycle n affects `i3` two cycles later. The result of a tick appears on outputs one cycle after that tick.
- Constant input held from reset gives an exact steady-state value at the first strobe. Pipeline fill is complete within 4*DECIM cycles.
- Reset asserted mid-frame: outputs drop to 0 immediately, with no partial-frame strobe. After release, warm-up restarts from `wu = 0`.
- `pdm` toggling on the tick cycle is absorbed into the next frame's integrator state. No sample is lost or duplicated.

## Test plan
- Constant `pdm=0` from reset -> first `sample_valid` at cycle 2048 with `sample=0x0000`. Strobes then repeat every 512 cycles, value 0x0000.
- Constant `pdm=1` -> first strobe at 2048, `sample=0xFFFF` (saturation path, no wrap to 0), held on every following strobe.
- Pattern 1,0,1,0,... -> `sample=0x8000` on every strobe. Pattern 1,0,0,0 repeating -> `sample=0x4000`.
- Loopback: drive the synth's sigma-delta DAC with constant din 0x3000 and feed its `data` to `pdm` -> after warm-up, `sample` within ±2 LSB of 0x3000 on every strobe.
- Long run of 10^6 cycles with `pdm=1` -> integrators wrap many times and every strobe still reads 0xFFFF (modular arithmetic check). `sample_valid` high exactly once per 512 cycles.
- Assert `rstn` at cycle 3000 (mid-frame) for 3 cycles -> outputs 0 asynchronously, no strobe during the partial frame. The next strobe is exactly 2048 cycles after release, with the correct value.
